// File: rtl/pc_call_stack_if.sv
// Control-unit to program-counter bus: redirect/call/return requests in,
// current instruction address and call-stack status out.
interface pc_call_stack_if #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);

  logic              stall;
  logic              jump;
  logic [ADDR_W-1:0] jump_adr;
  logic              branch;
  logic [ADDR_W-1:0] branch_adr;
  logic              call;
  logic [ADDR_W-1:0] call_adr;
  logic              ret;
  logic [ADDR_W-1:0] address;
  logic [LVL_W-1:0]  stack_level;
  logic              stack_overflow;
  logic              stack_underflow;

  // Control unit side: issues requests, observes the PC and stack status
  modport master (
    output stall, jump, jump_adr, branch, branch_adr, call, call_adr, ret,
    input  address, stack_level, stack_overflow, stack_underflow
  );

  // Program counter side: consumes requests, drives the PC and stack status
  modport slave (
    input  stall, jump, jump_adr, branch, branch_adr, call, call_adr, ret,
    output address, stack_level, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/pc_call_stack.sv
// Program counter with jump/branch redirect, stall, and a hardware
// call/return stack. Every output is a register; requests take effect
// on the address one clock after they are sampled.
module pc_call_stack #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0
) (
  input  logic               clk,
  input  logic               reset,
  pc_call_stack_if.slave     bus
);
  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(STACK_DEPTH);
  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_ADDR);

  // Return-address storage sized to a power of two so any pointer value is in range
  logic [ADDR_W-1:0] stack_mem [2**PTR_W];

  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push_en;
  logic [PTR_W-1:0]  top_idx;
  logic [PTR_W-1:0]  push_idx;

  assign pc_inc   = pc_q + 1'b1;
  assign top_idx  = PTR_W'(level_q - 1'b1);
  assign push_idx = PTR_W'(level_q);

  // Next-state selection in priority order: stall, ret, call, jump, branch, increment
  always_comb begin
    pc_d    = pc_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    if (!bus.stall) begin
      if (bus.ret) begin
        if (level_q != '0) begin
          pc_d    = stack_mem[top_idx];
          level_d = level_q - 1'b1;
        end else begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end
      end else if (bus.call) begin
        if (level_q < FULL_LEVEL) begin
          push_en = 1'b1;
          pc_d    = bus.call_adr;
          level_d = level_q + 1'b1;
        end else begin
          pc_d  = pc_inc;
          ovf_d = 1'b1;
        end
      end else if (bus.jump) begin
        pc_d = bus.jump_adr;
      end else if (bus.branch) begin
        pc_d = bus.branch_adr;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // PC, stack depth and sticky error flags, with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Push the return address; contents need no reset since only valid entries are read
  always_ff @(posedge clk) begin
    if (reset && push_en) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  assign bus.address         = pc_q;
  assign bus.stack_level     = level_q;
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;
endmodule

// File: tb/tb_pc_call_stack.sv
// Bench for pc_call_stack: directed walk-through of reset, redirect,
// call/return, overflow/underflow, stall and reset-during-ret, followed by
// random traffic, all compared against a queue-based reference model.
module tb_pc_call_stack;
  localparam int ADDR_W      = 8;
  localparam int STACK_DEPTH = 4;
  localparam int RESET_ADDR  = 0;
  localparam int ADDR_MOD    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset;

  pc_call_stack_if #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) bus ();

  pc_call_stack #(
    .ADDR_W     (ADDR_W),
    .STACK_DEPTH(STACK_DEPTH),
    .RESET_ADDR (RESET_ADDR)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the return stack is a plain queue, the PC an integer
  int m_pc  = RESET_ADDR;
  int m_stack[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  task automatic model_update(input bit rst, st, rt, cl, jp, br,
                              input int ja, ba, ca);
    if (!rst) begin
      m_pc = RESET_ADDR;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (st) begin
      // hold
    end else if (rt) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin
        m_pc  = (m_pc + 1) % ADDR_MOD;
        m_unf = 1'b1;
      end
    end else if (cl) begin
      if (m_stack.size() < STACK_DEPTH) begin
        m_stack.push_back((m_pc + 1) % ADDR_MOD);
        m_pc = ca;
      end else begin
        m_pc  = (m_pc + 1) % ADDR_MOD;
        m_ovf = 1'b1;
      end
    end else if (jp) begin
      m_pc = ja;
    end else if (br) begin
      m_pc = ba;
    end else begin
      m_pc = (m_pc + 1) % ADDR_MOD;
    end
  endtask

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_output();
    check_value("address", 32'(bus.address), 32'(m_pc));
    check_value("stack_level", 32'(bus.stack_level), 32'(m_stack.size()));
    check_value("stack_overflow", 32'(bus.stack_overflow), 32'(m_ovf));
    check_value("stack_underflow", 32'(bus.stack_underflow), 32'(m_unf));
  endtask

  // Drive one cycle of requests, clock it in, advance the model, compare
  task automatic apply_stimulus(input bit rst, st, rt, cl, jp, br,
                                input int ja, ba, ca);
    reset          = rst;
    bus.stall      = st;
    bus.ret        = rt;
    bus.call       = cl;
    bus.jump       = jp;
    bus.branch     = br;
    bus.jump_adr   = ADDR_W'(ja);
    bus.branch_adr = ADDR_W'(ba);
    bus.call_adr   = ADDR_W'(ca);
    @(posedge clk);
    #1;
    model_update(rst, st, rt, cl, jp, br, ja, ba, ca);
    check_output();
  endtask

  task automatic idle();      apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_jump(input int a);   apply_stimulus(1, 0, 0, 0, 1, 0, a, 0, 0); endtask
  task automatic do_branch(input int a); apply_stimulus(1, 0, 0, 0, 0, 1, 0, a, 0); endtask
  task automatic do_call(input int a);   apply_stimulus(1, 0, 0, 1, 0, 0, 0, 0, a); endtask
  task automatic do_ret();    apply_stimulus(1, 0, 1, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    reset = 1'b0;
    bus.stall = 0; bus.ret = 0; bus.call = 0; bus.jump = 0; bus.branch = 0;
    bus.jump_adr = '0; bus.branch_adr = '0; bus.call_adr = '0;

    $display("[TB] reset and increment");
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_value("reset_address", 32'(bus.address), 0);
    check_value("reset_level", 32'(bus.stack_level), 0);
    idle(); check_value("inc_1", 32'(bus.address), 1);
    idle(); check_value("inc_2", 32'(bus.address), 2);
    idle(); check_value("inc_3", 32'(bus.address), 3);
    do_jump(255);
    idle(); check_value("wrap_to_0", 32'(bus.address), 0);

    $display("[TB] jump, branch and priority");
    for (int i = 0; i < 6; i++) idle();
    check_value("at_6", 32'(bus.address), 6);
    do_jump(1); check_value("jump_1", 32'(bus.address), 1);
    idle(); idle(); check_value("after_jump_3", 32'(bus.address), 3);
    apply_stimulus(1, 0, 0, 0, 1, 1, 40, 128, 0);
    check_value("jump_beats_branch", 32'(bus.address), 40);
    do_branch(128); check_value("branch_128", 32'(bus.address), 128);
    idle(); check_value("after_branch", 32'(bus.address), 129);

    $display("[TB] call and return");
    do_jump(10);
    do_call(50); check_value("call_50", 32'(bus.address), 50);
    check_value("level_1", 32'(bus.stack_level), 1);
    idle(); idle();
    do_call(80); check_value("call_80", 32'(bus.address), 80);
    check_value("level_2", 32'(bus.stack_level), 2);
    do_ret(); check_value("ret_53", 32'(bus.address), 53);
    do_ret(); check_value("ret_11", 32'(bus.address), 11);
    check_value("level_0", 32'(bus.stack_level), 0);

    $display("[TB] overflow and underflow");
    do_call(100); do_call(110); do_call(120); do_call(130);
    do_call(140);
    check_value("overflow_address", 32'(bus.address), 131);
    check_value("overflow_level", 32'(bus.stack_level), 4);
    check_value("overflow_flag", 32'(bus.stack_overflow), 1);
    do_ret(); check_value("lifo_121", 32'(bus.address), 121);
    do_ret(); check_value("lifo_111", 32'(bus.address), 111);
    do_ret(); check_value("lifo_101", 32'(bus.address), 101);
    do_ret(); check_value("lifo_12", 32'(bus.address), 12);
    do_ret(); check_value("underflow_address", 32'(bus.address), 13);
    check_value("underflow_flag", 32'(bus.stack_underflow), 1);

    $display("[TB] stall");
    do_jump(20);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 1, 0, 0, 1, 0, 99, 0, 0);
      check_value("stall_hold", 32'(bus.address), 20);
    end
    idle(); check_value("after_stall", 32'(bus.address), 21);
    check_value("ovf_sticky", 32'(bus.stack_overflow), 1);
    check_value("unf_sticky", 32'(bus.stack_underflow), 1);

    $display("[TB] reset during ret");
    do_call(30); do_call(40);
    check_value("pre_reset_level", 32'(bus.stack_level), 2);
    apply_stimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
    check_value("mid_reset_address", 32'(bus.address), RESET_ADDR);
    check_value("mid_reset_level", 32'(bus.stack_level), 0);
    check_value("mid_reset_ovf", 32'(bus.stack_overflow), 0);
    do_ret(); check_value("post_reset_unf", 32'(bus.stack_underflow), 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      apply_stimulus(($urandom_range(63) != 0),
                     ($urandom_range(7) == 0),
                     ($urandom_range(4) == 0),
                     ($urandom_range(3) == 0),
                     ($urandom_range(5) == 0),
                     ($urandom_range(5) == 0),
                     int'($urandom_range(ADDR_MOD - 1)),
                     int'($urandom_range(ADDR_MOD - 1)),
                     int'($urandom_range(ADDR_MOD - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
